// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the front-end flush/stall controller.
// Holds the FSM encoding, stage indices and control-bundle field positions.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SHADOW = 2'd2
    } flush_state_t;

    localparam int STG_IF = 0;
    localparam int STG_ID = 1;

    localparam int CTRL_W_DEF = 10;

    // Control bundle is packed MSB-first as RegDst .. ALUop[1:0]
    localparam int CB_REGDST   = 9;
    localparam int CB_ALUSRC   = 8;
    localparam int CB_MEMTOREG = 7;
    localparam int CB_REGWRITE = 6;
    localparam int CB_MEMREAD  = 5;
    localparam int CB_MEMWRITE = 4;
    localparam int CB_BRANCH   = 3;
    localparam int CB_JRCTRL   = 2;
    localparam int CB_ALUOP_HI = 1;
    localparam int CB_ALUOP_LO = 0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter: counts cycles with inc high and sticks at all-ones.
module sat_event_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_flush_ctrl.sv
// Front-end flush/stall controller: turns redirects and load-use hazards into
// stage flushes, PC/IF-ID write enables and a bubbled ID control bundle.
module pipe_flush_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int N_STAGES  = 2,
    parameter int JMP_DEPTH = 1,
    parameter int BR_DEPTH  = 2,
    parameter int IMEM_LAT  = 1,
    parameter int STALL_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jump,
    input  logic                bne,
    input  logic                jr,
    input  logic                load_use,
    input  logic [CTRL_W-1:0]   ctrl_in,
    output logic [N_STAGES-1:0] flush_vec,
    output logic [CTRL_W-1:0]   ctrl_out,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                busy,
    output logic [CNT_W-1:0]    flush_count
);

    if (JMP_DEPTH < 1 || JMP_DEPTH > BR_DEPTH || BR_DEPTH > N_STAGES ||
        IMEM_LAT < 1 || STALL_CYC < 1) begin : g_bad_params
        $error("pipe_flush_ctrl: need 1 <= JMP_DEPTH <= BR_DEPTH <= N_STAGES, IMEM_LAT >= 1, STALL_CYC >= 1");
    end

    localparam int CNT_MAX = max_int(IMEM_LAT, STALL_CYC);
    localparam int DCNT_W  = $clog2(CNT_MAX + 1);

    localparam logic [N_STAGES-1:0] JMP_MASK = {N_STAGES{1'b1}} >> (N_STAGES - JMP_DEPTH);
    localparam logic [N_STAGES-1:0] BR_MASK  = {N_STAGES{1'b1}} >> (N_STAGES - BR_DEPTH);
    localparam logic [DCNT_W-1:0] SHADOW_LOAD = DCNT_W'(IMEM_LAT - 1);
    localparam logic [DCNT_W-1:0] STALL_LOAD  = DCNT_W'(STALL_CYC - 1);

    flush_state_t      state, state_next;
    logic [DCNT_W-1:0] cnt, cnt_next;
    logic              redir;
    logic              br_redir;
    logic [N_STAGES-1:0] redir_mask;

    assign br_redir   = bne | jr;
    assign redir      = jump | br_redir;
    assign redir_mask = br_redir ? BR_MASK : (jump ? JMP_MASK : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A redirect always wins: it aborts a stall and restarts any shadow window.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (redir) begin
            if (IMEM_LAT > 1) begin
                state_next = SHADOW;
                cnt_next   = SHADOW_LOAD;
            end else begin
                state_next = RUN;
                cnt_next   = '0;
            end
        end else begin
            unique case (state)
                RUN: begin
                    if (load_use && (STALL_CYC > 1)) begin
                        state_next = STALL;
                        cnt_next   = STALL_LOAD;
                    end
                end
                STALL, SHADOW: begin
                    if (cnt <= DCNT_W'(1)) begin
                        state_next = RUN;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt - DCNT_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        logic                bubble;
        logic                kill_id;
        logic [N_STAGES-1:0] flush;

        bubble = 1'b0;
        flush  = '0;
        if (redir) begin
            flush = redir_mask;
        end else if ((state == RUN && load_use) || state == STALL) begin
            bubble = 1'b1;
        end
        // Wrong-path fetch returns keep arriving until the latency window closes
        if (state == SHADOW) begin
            flush[STG_IF] = 1'b1;
        end

        kill_id    = (N_STAGES >= 2) && flush[STG_ID % N_STAGES];
        flush_vec  = flush;
        pc_write   = ~bubble;
        ifid_write = ~bubble;
        ctrl_out   = (bubble || kill_id) ? '0 : ctrl_in;

        if (reset) begin
            flush_vec  = '1;
            ctrl_out   = '0;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end
    end

    assign busy = (state != RUN);

    sat_event_counter #(
        .W(CNT_W)
    ) u_flush_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (redir),
        .count(flush_count)
    );

endmodule

// File: doc/pipe_flush_ctrl.md
Name: pipe_flush_ctrl

Overview:
- Parametrised, stateful successor to the per-cycle flush logic.
- Turns redirect events (jump, taken bne, jr) and load-use hazards into per-stage flush vectors, PC/IF-ID write enables and a bubbled ID control bundle.
- Handles multi-cycle instruction-memory latency by holding a wrong-path shadow window, and multi-cycle stalls.
- Keeps a saturating flush-event counter.
- Sits between the main decoder/hazard detector and the ID/EX pipeline register.

Parameters:
- CTRL_W, 10: width of the control bundle, i.e. RegDst, ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, JRControl, ALUop[1:0].
- N_STAGES, 2: number of front-end stages that can be flushed; bit 0 is IF, bit 1 is ID.
- JMP_DEPTH, 1: number of youngest stages flushed on a jump.
- BR_DEPTH, 2: number of youngest stages flushed on a taken bne or a jr.
- IMEM_LAT, 1: instruction-fetch latency in cycles.
- STALL_CYC, 1: bubble cycles inserted per load-use hazard.
- CNT_W, 16: flush_count width.

Ports:
- clk in 1: system clock.
- reset in 1: synchronous, active-high reset.
- jump in 1: jump decoded in ID.
- bne in 1: bne resolved taken.
- jr in 1: jr resolved.
- load_use in 1: load-use hazard request from the hazard detector.
- ctrl_in in CTRL_W: control bundle from the main decoder.
- flush_vec out N_STAGES: per-stage flush, bit i flushes stage i.
- ctrl_out out CTRL_W: control bundle to the ID/EX register.
- pc_write out 1: PC update enable.
- ifid_write out 1: IF/ID register write enable.
- busy out 1: FSM is not in RUN.
- flush_count out CNT_W: number of redirect events, saturating.

Behaviour:
- Reset is one clock, synchronous, active-high. Clocking one edge with reset high is sufficient.
- While reset is high: flush_vec = all ones, ctrl_out = 0, pc_write = 0, ifid_write = 0.
- Registered state after reset: FSM = RUN, down-counter = 0, flush_count = 0, busy = 0.
- Elaboration error unless 1 <= JMP_DEPTH <= BR_DEPTH <= N_STAGES, IMEM_LAT >= 1 and STALL_CYC >= 1.
- Redirect priority: bne or jr outranks jump. When both are present, BR_DEPTH applies.
- Any redirect outranks load_use; the pending stall is discarded.
- redir = jump | bne | jr. Redirect outputs are combinational, with zero-cycle latency in the event cycle.
- flush_vec ones mask: bne | jr gives bits [BR_DEPTH-1:0]; otherwise jump gives bits [JMP_DEPTH-1:0].
- ctrl_out = 0 whenever flush_vec[1] = 1 (when N_STAGES >= 2) or a stall bubble is active; otherwise ctrl_out = ctrl_in.
- FSM state RUN:
  - On redir: apply the flush mask. If IMEM_LAT > 1, go to SHADOW with cnt = IMEM_LAT-1; otherwise stay in RUN.
  - Else on load_use: bubble this cycle (ctrl_out = 0, pc_write = 0, ifid_write = 0). If STALL_CYC > 1, go to STALL with cnt = STALL_CYC-1.
  - Otherwise pc_write = ifid_write = 1 and ctrl_out passes ctrl_in.
- FSM state STALL:
  - Bubble every cycle; cnt decrements; when cnt = 1 return to RUN on the next edge.
  - load_use during STALL is ignored; it is not extended.
  - redir during STALL aborts the stall and behaves exactly as redir in RUN.
- FSM state SHADOW:
  - flush_vec[0] = 1 to discard wrong-path fetch returns; pc_write = ifid_write = 1.
  - cnt decrements; when cnt = 1 return to RUN.
  - A new redir restarts the window: mask applied, cnt reloaded.
  - load_use during SHADOW is ignored.
- flush_count increments by 1 on each cycle in which redir = 1, and holds at all-ones.
- Reset mid-STALL or mid-SHADOW returns to RUN on the next edge; the counter is cleared.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, STALL, SHADOW);
  - stage index constants STG_IF = 0 and STG_ID = 1;
  - the default CTRL_W;
  - the localparam bit positions of the control-bundle fields.
- One sub-module, sat_event_counter: a parameterised CNT_W saturating incrementer with synchronous reset, used for flush_count.

Test Plan:
- Defaults, jump = 1 for one cycle -> flush_vec = 2'b01, ctrl_out = ctrl_in, flush_count 0 -> 1, busy stays 0.
- Defaults, bne = 1 and jump = 1 in the same cycle, ctrl_in = 10'h3FF -> flush_vec = 2'b11, ctrl_out = 0, flush_count increments by 1.
- STALL_CYC = 3, load_use pulse -> 3 consecutive cycles with pc_write = 0, ifid_write = 0, ctrl_out = 0, busy = 1 in cycles 2-3, then normal flow.
- STALL_CYC = 3, load_use then jr on the 2nd bubble cycle -> that cycle flush_vec = 2'b11; next cycle pc_write = 1, busy = 0.
- IMEM_LAT = 3, jump -> flush_vec = 01 for 3 cycles, busy = 1 for 2; a second jump in cycle 2 extends the window to cycle 4.
- CNT_W = 2 with 5 jump cycles -> flush_count = 3 and holds. Reset asserted mid-SHADOW -> flush_vec = 11, pc_write = 0, then RUN with count 0.
